// File: rtl/collision_pkg.sv
// Collision bit positions, the collision vector type and the raw (unmasked) collision map.
package collision_pkg;

  localparam int COL_PLAYER          = 0;
  localparam int COL_SHOT            = 1;
  localparam int COL_ENEMY_SHOT      = 2;
  localparam int COL_PMISSILE_BORDER = 3;
  localparam int COL_EMISSILE_BORDER = 4;
  localparam int COL_ENEMY_BORDER    = 5;
  localparam int COL_PLAYER_BORDER   = 6;

  typedef logic [6:0] collision_t;

  function automatic collision_t raw_collisions(
    input logic player,
    input logic pmissile,
    input logic monsters,
    input logic mmissile,
    input logic asteroids,
    input logic borders
  );
    collision_t r;
    logic enemy;
    enemy = asteroids | monsters;
    r = '0;
    r[COL_PLAYER]          = player & enemy;
    r[COL_SHOT]            = pmissile & enemy;
    r[COL_ENEMY_SHOT]      = mmissile & player;
    r[COL_PMISSILE_BORDER] = pmissile & borders;
    r[COL_EMISSILE_BORDER] = mmissile & borders;
    r[COL_ENEMY_BORDER]    = enemy & borders;
    r[COL_PLAYER_BORDER]   = player & borders;
    return r;
  endfunction

endpackage

// File: rtl/frame_sticky.sv
// Per-frame OR accumulator; on startOfFrame the closing frame (including the same-cycle
// input) is snapshotted and the accumulator restarts empty.
module frame_sticky #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_of_frame,
  input  logic             hold,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] snapshot
);

  logic [WIDTH-1:0] acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      snapshot <= '0;
    end else if (start_of_frame) begin
      snapshot <= acc | din;
      acc      <= '0;
    end else if (!hold) begin
      acc <= acc | din;
    end
  end

endmodule

// File: rtl/collision_detector.sv
// Registered per-pixel collision vector with per-frame summary, one player-hit pulse per
// frame and a frame-counted invulnerability window that masks player damage bits.
module collision_detector
  import collision_pkg::*;
#(
  parameter int INVULN_FRAMES = 30,
  parameter int NUM_BITS      = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       enable,
  input  logic       playerDR,
  input  logic       playerMissileDR,
  input  logic       monstersDR,
  input  logic       monsterMissileDR,
  input  logic       asteroidsDR,
  input  logic       bordersDR,
  output collision_t collision,
  output collision_t frame_collisions,
  output logic       player_hit_pulse,
  output logic       invulnerable
);

  localparam logic [7:0] INV_LOAD = 8'(INVULN_FRAMES);

  collision_t raw;
  collision_t mask;
  collision_t col_q;
  logic       hit;
  logic       hit_prev;
  logic       hit_seen;
  logic       pulse_d;
  logic       pulse_q;
  logic [7:0] inv_cnt;

  assign raw = raw_collisions(playerDR, playerMissileDR, monstersDR,
                              monsterMissileDR, asteroidsDR, bordersDR);

  // Border bit for the player stays live during invulnerability so it still stops at walls.
  always_comb begin
    mask = '1;
    if (!enable) begin
      mask = '0;
    end else if (inv_cnt != 8'd0) begin
      mask[COL_PLAYER]     = 1'b0;
      mask[COL_ENEMY_SHOT] = 1'b0;
    end
  end

  assign hit     = col_q[COL_PLAYER] | col_q[COL_ENEMY_SHOT];
  assign pulse_d = enable & hit & ~hit_prev & ~hit_seen;

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q    <= '0;
      hit_prev <= 1'b0;
      hit_seen <= 1'b0;
      pulse_q  <= 1'b0;
      inv_cnt  <= 8'd0;
    end else begin
      col_q    <= raw & mask;
      hit_prev <= hit;
      pulse_q  <= pulse_d;
      if (pulse_d)
        hit_seen <= 1'b1;
      else if (startOfFrame)
        hit_seen <= 1'b0;
      // A load coinciding with startOfFrame wins; the hit frame is the first one counted down.
      if (pulse_q)
        inv_cnt <= INV_LOAD;
      else if (startOfFrame && enable && inv_cnt != 8'd0)
        inv_cnt <= inv_cnt - 8'd1;
    end
  end

  frame_sticky #(.WIDTH(NUM_BITS)) u_frame_sticky (
    .clk           (clk),
    .reset         (reset),
    .start_of_frame(startOfFrame),
    .hold          (~enable),
    .din           (col_q),
    .snapshot      (frame_collisions)
  );

  assign collision        = col_q;
  assign player_hit_pulse = pulse_q;
  assign invulnerable     = (inv_cnt != 8'd0);

  param_check: assert property (@(posedge clk)
    (INVULN_FRAMES >= 1) && (INVULN_FRAMES <= 255) && (NUM_BITS == 7));

endmodule
